// File: rtl/bcd_to_excess3_seq.sv
// Sequential multi-digit BCD to Excess-3 encoder, one digit per clock, LSB digit first.
// Digits above 9 are still encoded (4-bit wrap) and flagged in err_mask.
module bcd_to_excess3_seq #(
   parameter int unsigned DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [4*DIGITS-1:0]   bcd_in,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [4*DIGITS-1:0]   xs3_out,
   output logic [DIGITS-1:0]     err_mask
);

   localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   typedef enum logic [1:0] {StIdle, StConv, StDone} state_e;

   state_e                state_q, state_d;
   logic [IdxW-1:0]       idx_q, idx_d;
   logic [4*DIGITS-1:0]   word_q, word_d;
   logic [4*DIGITS-1:0]   xs3_q, xs3_d;
   logic [DIGITS-1:0]     err_q, err_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         idx_q   <= '0;
         word_q  <= '0;
         xs3_q   <= '0;
         err_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         word_q  <= word_d;
         xs3_q   <= xs3_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      word_d  = word_q;
      xs3_d   = xs3_q;
      err_d   = err_q;
      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               word_d  = bcd_in;
               xs3_d   = '0;
               err_d   = '0;
               idx_d   = '0;
               state_d = StConv;
            end
         end
         StConv: begin
            // Constant-index decode keeps the digit select lint-clean for any DIGITS.
            for (int i = 0; i < DIGITS; i++) begin
               if (idx_q == IdxW'(i)) begin
                  xs3_d[4*i +: 4] = word_q[4*i +: 4] + 4'd3;
                  err_d[i]        = (word_q[4*i +: 4] > 4'd9);
               end
            end
            if (idx_q == IdxW'(DIGITS - 1)) begin
               state_d = StDone;
            end else begin
               idx_d = idx_q + IdxW'(1);
            end
         end
         StDone: begin
            if (out_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign in_ready  = (state_q == StIdle);
   assign out_valid = (state_q == StDone);
   assign xs3_out   = xs3_q;
   assign err_mask  = err_q;

endmodule

// File: tb/tb_bcd_to_excess3_seq.sv
// Directed self-checking bench for bcd_to_excess3_seq (DIGITS=4 and DIGITS=1 builds).
module tb_bcd_to_excess3_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready, out_valid, out_ready;
   logic [15:0] bcd_in, xs3_out;
   logic [3:0]  err_mask;

   logic        in_valid1, in_ready1, out_valid1, out_ready1;
   logic [3:0]  bcd_in1, xs3_out1;
   logic [0:0]  err_mask1;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   bcd_to_excess3_seq #(.DIGITS(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .bcd_in    (bcd_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .xs3_out   (xs3_out),
      .err_mask  (err_mask)
   );

   bcd_to_excess3_seq #(.DIGITS(1)) dut1 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid1),
      .in_ready  (in_ready1),
      .bcd_in    (bcd_in1),
      .out_valid (out_valid1),
      .out_ready (out_ready1),
      .xs3_out   (xs3_out1),
      .err_mask  (err_mask1)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Called at a negedge; leaves at the negedge after the output handshake.
   task automatic send4(input string tag, input logic [15:0] w, input logic [15:0] ex,
                        input logic [3:0] ee);
      int cyc = 0;
      while (!in_ready && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      check({tag, "_rdy"}, 32'(in_ready), 32'd1);
      bcd_in    = w;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      bcd_in   = ~w;
      cyc = 0;
      while (!out_valid && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      check({tag, "_lat"}, 32'(cyc), 32'd4);
      check({tag, "_xs3"}, 32'(xs3_out), 32'(ex));
      check({tag, "_err"}, 32'(err_mask), 32'(ee));
      @(negedge clk);
      check({tag, "_vld_drop"}, {30'd0, out_valid, in_ready}, 32'b01);
   endtask

   task automatic send1(input string tag, input logic [3:0] d, input logic [3:0] ex,
                        input logic ee);
      int cyc = 0;
      bcd_in1    = d;
      in_valid1  = 1'b1;
      out_ready1 = 1'b1;
      @(negedge clk);
      in_valid1 = 1'b0;
      while (!out_valid1 && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      check({tag, "_lat"}, 32'(cyc), 32'd1);
      check({tag, "_xs3"}, 32'(xs3_out1), 32'(ex));
      check({tag, "_err"}, 32'(err_mask1), 32'(ee));
      @(negedge clk);
      check({tag, "_rdy"}, {30'd0, out_valid1, in_ready1}, 32'b01);
   endtask

   initial begin
      int cyc;
      logic [15:0] w, gx;
      logic [3:0]  ge, d;

      rst        = 1'b1;
      in_valid   = 1'b1;
      bcd_in     = 16'hFFFF;
      out_ready  = 1'b0;
      in_valid1  = 1'b0;
      bcd_in1    = 4'h0;
      out_ready1 = 1'b0;
      repeat (3) @(negedge clk);
      // Reset wins over a concurrent in_valid.
      check("rst_ready", 32'(in_ready), 32'd1);
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_xs3", 32'(xs3_out), 32'd0);
      check("rst_err", 32'(err_mask), 32'd0);
      rst      = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      check("post_rst_idle", {30'd0, out_valid, in_ready}, 32'b01);

      send4("t1", 16'h1234, 16'h4567, 4'b0000);
      send4("t2a", 16'h0999, 16'h3CCC, 4'b0000);
      send4("t2b", 16'h0000, 16'h3333, 4'b0000);
      send4("t3", 16'h9A0F, 16'hCD32, 4'b0101);

      // Backpressure in DONE; a word offered meanwhile must be dropped.
      bcd_in    = 16'h1234;
      in_valid  = 1'b1;
      out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      cyc = 0;
      while (!out_valid && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      check("t4_lat", 32'(cyc), 32'd4);
      in_valid = 1'b1;
      bcd_in   = 16'h5555;
      for (int i = 0; i < 5; i++) begin
         check("t4_hold", {15'd0, out_valid, in_ready, xs3_out}, {15'd0, 2'b10, 16'h4567});
         @(negedge clk);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      check("t4_release", {15'd0, out_valid, in_ready, xs3_out}, {15'd0, 2'b01, 16'h4567});
      send4("t4_next", 16'h5555, 16'h8888, 4'b0000);

      // Reset during the second CONV cycle.
      bcd_in   = 16'h4321;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("t5_ready", 32'(in_ready), 32'd1);
      check("t5_valid", 32'(out_valid), 32'd0);
      check("t5_xs3", 32'(xs3_out), 32'd0);
      check("t5_err", 32'(err_mask), 32'd0);
      repeat (6) @(negedge clk);
      check("t5_quiet", {30'd0, out_valid, in_ready}, 32'b01);
      send4("t5_next", 16'h0001, 16'h3334, 4'b0000);

      // Every digit value in every position, back to back.
      for (int v = 0; v < 16; v++) begin
         for (int i = 0; i < 4; i++) begin
            d             = 4'(v + i);
            w[4*i +: 4]   = d;
            gx[4*i +: 4]  = 4'(d + 4'd3);
            ge[i]         = (d > 4'd9);
         end
         send4($sformatf("t6_%0d", v), w, gx, ge);
      end

      check("d1_idle", 32'(in_ready1), 32'd1);
      for (int v = 0; v < 16; v++) begin
         d = 4'(v);
         send1($sformatf("d1_%0d", v), d, 4'(d + 4'd3), (d > 4'd9));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
